iob_ram_2p_arb: RTL and testbench

Round-robin arbiter that shares one two-port RAM (separate write and read ports, 1-cycle registered read) among N_REQ requesters. The write and read ports are arbitrated independently, so one write and one read can be granted in the same cycle. Each read response is routed back to its requester with a fixed 1-cycle latency. The block sits between client engines and the iob_ram_2p instance; the RAM is instantiated outside this block with WRITE_FIRST=1.

---
 rtl/iob_ram_2p_arb_pkg.sv | 19 +
 rtl/iob_rr_arbiter.sv | 87 ++++++++
 rtl/iob_ram_2p_arb.sv | 137 +++++++++++++
 tb/tb_iob_ram_2p_arb.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_ram_2p_arb_pkg.sv
// Shared definitions for the iob_ram_2p_arb block: arbiter FSM encoding,
// stall counter width and the pointer-width helper.
package iob_ram_2p_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam int STALL_CNT_W = 16;

  // Width of a requester index; never below one bit so N=1 still elaborates.
  function automatic int ptr_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter with a grant lock, one instance per RAM port.
//   clk_i, arst_n_i : clock, async active-low reset
//   cke             : clock enable, state and pointer hold when low
//   req[N]          : per-requester valid
//   ready           : RAM port ready
//   grant[N]        : one-hot current grant (drives the RAM port)
//   grant_idx       : binary index of the current grant
//   accept          : granted request taken by the RAM this cycle
module iob_rr_arbiter
  import iob_ram_2p_arb_pkg::*;
#(
  parameter  int N     = 2,
  localparam int PTR_W = ptr_w(N)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             cke,
  input  logic [N-1:0]     req,
  input  logic             ready,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             accept
);

  arb_state_t       state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [PTR_W-1:0] lock_idx, lock_idx_nxt;
  logic [PTR_W-1:0] pick, cand;
  logic             found, gnt_vld;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = PTR_W'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    lock_idx_nxt = lock_idx;
    gnt_vld      = 1'b0;
    grant_idx    = '0;
    case (state)
      ARB_IDLE: begin
        gnt_vld   = found;
        grant_idx = pick;
      end
      ARB_LOCK: begin
        gnt_vld   = 1'b1;
        grant_idx = lock_idx;
      end
      default: ;
    endcase
    // Outputs are forced quiet while reset is held.
    gnt_vld = gnt_vld & arst_n_i;
    accept  = gnt_vld & req[grant_idx] & ready & cke;
    grant   = gnt_vld ? (N'(1) << grant_idx) : '0;
    if (accept) begin
      state_nxt = ARB_IDLE;
      ptr_nxt   = (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end else if (gnt_vld && (state == ARB_IDLE)) begin
      state_nxt    = ARB_LOCK;
      lock_idx_nxt = grant_idx;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state    <= ARB_IDLE;
      ptr      <= '0;
      lock_idx <= '0;
    end else if (cke) begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      lock_idx <= lock_idx_nxt;
    end
  end

endmodule

// File: rtl/iob_ram_2p_arb.sv
// Shares one two-port RAM (write port + 1-cycle registered read port) among
// N_REQ requesters. Write and read ports are arbitrated independently by
// round-robin arbiters; read data is returned one cycle after accept with a
// one-hot response valid.
// Ports: clk_i/arst_n_i/cke_i; per-requester write request (valid/addr/data,
// ready), read request (valid/addr, ready), read response (one-hot valid,
// shared data); RAM write port (en/addr/data, ready) and read port
// (en/addr, data, ready).
// Optional build macro IOB_RAM_2P_ARB_STATS_EN adds per-requester 16-bit
// saturating stall counters (stall_cnt_o) and a synchronous clear
// (stall_clr_i).
module iob_ram_2p_arb
  import iob_ram_2p_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic                      cke_i,
  input  logic [N_REQ-1:0]          wreq_valid_i,
  input  logic [N_REQ*ADDR_W-1:0]   wreq_addr_i,
  input  logic [N_REQ*DATA_W-1:0]   wreq_data_i,
  output logic [N_REQ-1:0]          wreq_ready_o,
  input  logic [N_REQ-1:0]          rreq_valid_i,
  input  logic [N_REQ*ADDR_W-1:0]   rreq_addr_i,
  output logic [N_REQ-1:0]          rreq_ready_o,
  output logic [N_REQ-1:0]          rresp_valid_o,
  output logic [DATA_W-1:0]         rresp_data_o,
  output logic                      ram_w_en_o,
  output logic [ADDR_W-1:0]         ram_w_addr_o,
  output logic [DATA_W-1:0]         ram_w_data_o,
  input  logic                      ram_w_ready_i,
  output logic                      ram_r_en_o,
  output logic [ADDR_W-1:0]         ram_r_addr_o,
  input  logic [DATA_W-1:0]         ram_r_data_i,
  input  logic                      ram_r_ready_i
`ifdef IOB_RAM_2P_ARB_STATS_EN
  ,
  input  logic                      stall_clr_i,
  output logic [N_REQ*STALL_CNT_W-1:0] stall_cnt_o
`endif
);

  localparam int PTR_W = ptr_w(N_REQ);

  logic [N_REQ-1:0]  wgrant, rgrant;
  logic [PTR_W-1:0]  widx, ridx;
  logic              waccept, raccept;
  logic [N_REQ-1:0]  rresp_vld_p1;
  logic [DATA_W-1:0] rdata_hold_p1;

  iob_rr_arbiter #(.N(N_REQ)) u_warb (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke      (cke_i),
    .req      (wreq_valid_i),
    .ready    (ram_w_ready_i),
    .grant    (wgrant),
    .grant_idx(widx),
    .accept   (waccept)
  );

  iob_rr_arbiter #(.N(N_REQ)) u_rarb (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke      (cke_i),
    .req      (rreq_valid_i),
    .ready    (ram_r_ready_i),
    .grant    (rgrant),
    .grant_idx(ridx),
    .accept   (raccept)
  );

  assign wreq_ready_o = {N_REQ{waccept}} & wgrant;
  assign rreq_ready_o = {N_REQ{raccept}} & rgrant;
  assign ram_w_en_o   = |wgrant;
  assign ram_r_en_o   = |rgrant;

  // RAM port drive: selected slice of the granted requester, zero when idle.
  always_comb begin
    ram_w_addr_o = '0;
    ram_w_data_o = '0;
    ram_r_addr_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (ram_w_en_o && (widx == PTR_W'(k))) begin
        ram_w_addr_o = wreq_addr_i[k*ADDR_W +: ADDR_W];
        ram_w_data_o = wreq_data_i[k*DATA_W +: DATA_W];
      end
      if (ram_r_en_o && (ridx == PTR_W'(k))) begin
        ram_r_addr_o = rreq_addr_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // Stage p1: read response. RAM data arrives one cycle after accept, so the
  // response cycle passes it straight through; the hold register keeps the
  // last delivered word on the bus between responses.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rresp_vld_p1  <= '0;
      rdata_hold_p1 <= '0;
    end else if (cke_i) begin
      rresp_vld_p1 <= rreq_ready_o;
      if (|rresp_vld_p1) rdata_hold_p1 <= ram_r_data_i;
    end
  end

  assign rresp_valid_o = rresp_vld_p1;
  assign rresp_data_o  = (|rresp_vld_p1) ? ram_r_data_i : rdata_hold_p1;

`ifdef IOB_RAM_2P_ARB_STATS_EN
  logic [N_REQ-1:0]       blocked;
  logic [STALL_CNT_W-1:0] stall_cnt [N_REQ];

  // A requester stalls when it asks on either port and is not taken there.
  assign blocked = (wreq_valid_i & ~wreq_ready_o) | (rreq_valid_i & ~rreq_ready_o);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int k = 0; k < N_REQ; k++) stall_cnt[k] <= '0;
    end else if (cke_i) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (stall_clr_i) stall_cnt[k] <= '0;
        else if (blocked[k] && (stall_cnt[k] != '1)) stall_cnt[k] <= stall_cnt[k] + 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_o = '0;
    for (int k = 0; k < N_REQ; k++) stall_cnt_o[k*STALL_CNT_W +: STALL_CNT_W] = stall_cnt[k];
  end
`endif

endmodule

// File: tb/tb_iob_ram_2p_arb.sv
// Bench for iob_ram_2p_arb (N_REQ=2): directed scenarios followed by a
// randomized phase, all checked against a behavioural arbiter/RAM model.
module tb_iob_ram_2p_arb;

  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_n, cke;
  logic [N-1:0]  wv, rv;
  logic [AW-1:0] wa [N];
  logic [AW-1:0] ra [N];
  logic [DW-1:0] wd [N];
  logic [N*AW-1:0] wreq_addr, rreq_addr;
  logic [N*DW-1:0] wreq_data;
  logic [N-1:0]  wready, rready, rresp_valid;
  logic [DW-1:0] rresp_data, ram_w_data;
  logic [DW-1:0] ram_r_data = '0;
  logic [AW-1:0] ram_w_addr, ram_r_addr;
  logic          ram_w_en, ram_r_en, ram_w_rdy, ram_r_rdy;
`ifdef IOB_RAM_2P_ARB_STATS_EN
  logic            stall_clr;
  logic [N*16-1:0] stall_cnt;
`endif

  always_comb begin
    wreq_addr = '0;
    rreq_addr = '0;
    wreq_data = '0;
    for (int k = 0; k < N; k++) begin
      wreq_addr[k*AW +: AW] = wa[k];
      rreq_addr[k*AW +: AW] = ra[k];
      wreq_data[k*DW +: DW] = wd[k];
    end
  end

  iob_ram_2p_arb #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .cke_i        (cke),
    .wreq_valid_i (wv),
    .wreq_addr_i  (wreq_addr),
    .wreq_data_i  (wreq_data),
    .wreq_ready_o (wready),
    .rreq_valid_i (rv),
    .rreq_addr_i  (rreq_addr),
    .rreq_ready_o (rready),
    .rresp_valid_o(rresp_valid),
    .rresp_data_o (rresp_data),
    .ram_w_en_o   (ram_w_en),
    .ram_w_addr_o (ram_w_addr),
    .ram_w_data_o (ram_w_data),
    .ram_w_ready_i(ram_w_rdy),
    .ram_r_en_o   (ram_r_en),
    .ram_r_addr_o (ram_r_addr),
    .ram_r_data_i (ram_r_data),
    .ram_r_ready_i(ram_r_rdy)
`ifdef IOB_RAM_2P_ARB_STATS_EN
    ,
    .stall_clr_i  (stall_clr),
    .stall_cnt_o  (stall_cnt)
`endif
  );

  // External RAM: registered read, write-first on same-address collision.
  logic [DW-1:0] mem [1024];
  logic          mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      mem_init_done <= 1'b1;
    end else if (cke) begin
      if (ram_w_en && ram_w_rdy) mem[ram_w_addr] <= ram_w_data;
      if (ram_r_en && ram_r_rdy)
        ram_r_data <= (ram_w_en && ram_w_rdy && (ram_w_addr == ram_r_addr)) ? ram_w_data : mem[ram_r_addr];
    end
  end

  // Reference model state.
  int            checks = 0;
  int            failures = 0;
  int            wptr, rptr, wlock, rlock;
  bit            exp_rvld;
  int            exp_ridx;
  logic [DW-1:0] exp_rdata_cur, exp_rdata_last;
  logic [DW-1:0] ref_mem [1024];
  int            stall_m [N];
  int            last_wacc, last_racc;
  bit            pend_w [N];
  bit            pend_r [N];
  bit            allow_new;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int ptr, input int lock, input logic [N-1:0] v);
    if (lock >= 0) return lock;
    for (int i = 0; i < N; i++) if (v[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    wptr = 0; rptr = 0; wlock = -1; rlock = -1;
    exp_rvld = 1'b0; exp_ridx = 0;
    exp_rdata_cur = '0; exp_rdata_last = '0;
    for (int k = 0; k < N; k++) stall_m[k] = 0;
  endtask

  // Called 1 time unit after a rising edge with inputs already applied:
  // checks every output against the model, advances the model, clocks.
  task automatic step();
    int gw, gr;
    bit wacc, racc, blk;
    #2;
    gw = arst_n ? pick(wptr, wlock, wv) : -1;
    gr = arst_n ? pick(rptr, rlock, rv) : -1;
    wacc = 1'b0;
    racc = 1'b0;
    if (gw >= 0) wacc = ram_w_rdy && cke && wv[gw];
    if (gr >= 0) racc = ram_r_rdy && cke && rv[gr];
    chk("w_ready", wready, wacc ? (1 << gw) : 0);
    chk("r_ready", rready, racc ? (1 << gr) : 0);
    chk("w_en", ram_w_en, gw >= 0);
    chk("r_en", ram_r_en, gr >= 0);
    chk("w_addr", ram_w_addr, (gw >= 0) ? wa[gw] : 0);
    chk("w_data", ram_w_data, (gw >= 0) ? wd[gw] : 0);
    chk("r_addr", ram_r_addr, (gr >= 0) ? ra[gr] : 0);
    chk("rresp_valid", rresp_valid, exp_rvld ? (1 << exp_ridx) : 0);
    chk("rresp_data", rresp_data, exp_rvld ? exp_rdata_cur : exp_rdata_last);
`ifdef IOB_RAM_2P_ARB_STATS_EN
    for (int k = 0; k < N; k++) chk($sformatf("stall_cnt%0d", k), stall_cnt[k*16 +: 16], stall_m[k]);
`endif
    last_wacc = wacc ? gw : -1;
    last_racc = racc ? gr : -1;
    if (!arst_n) begin
      model_reset();
    end else if (cke) begin
`ifdef IOB_RAM_2P_ARB_STATS_EN
      for (int k = 0; k < N; k++) begin
        blk = (wv[k] && last_wacc != k) || (rv[k] && last_racc != k);
        if (stall_clr) stall_m[k] = 0;
        else if (blk && stall_m[k] < 16'hFFFF) stall_m[k]++;
      end
`endif
      if (exp_rvld) exp_rdata_last = exp_rdata_cur;
      exp_rvld = racc;
      if (racc) begin
        exp_ridx = gr;
        exp_rdata_cur = (wacc && wa[gw] == ra[gr]) ? wd[gw] : ref_mem[ra[gr]];
      end
      if (wacc) ref_mem[wa[gw]] = wd[gw];
      if (wacc) begin wptr = (gw + 1) % N; wlock = -1; end
      else if (gw >= 0) wlock = gw;
      if (racc) begin rptr = (gr + 1) % N; rlock = -1; end
      else if (gr >= 0) rlock = gr;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0; cke = 1'b1; wv = '0; rv = '0;
    ram_w_rdy = 1'b1; ram_r_rdy = 1'b1;
    for (int k = 0; k < N; k++) begin wa[k] = '0; ra[k] = '0; wd[k] = '0; pend_w[k] = 0; pend_r[k] = 0; end
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
`ifdef IOB_RAM_2P_ARB_STATS_EN
    stall_clr = 1'b0;
`endif
    model_reset();
    @(posedge clk); #1;

    // Reset state, with a request pending to show outputs stay quiet.
    wv = 2'b01;
    step();
    step();
    wv = '0;
    arst_n = 1'b1;
    step();

    // Contention: both writers hold valid, grants alternate 0,1,0,1.
    wa[0] = 10'd1; wd[0] = 32'h11; wa[1] = 10'd2; wd[1] = 32'h22;
    wv = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("contention_grant%0d", i), wready, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    wv = '0;
    step();

    // Lock: req1 granted while RAM not ready, req0 joins; grant must stay.
    ram_w_rdy = 1'b0;
    wv = 2'b10; wa[1] = 10'd20; wd[1] = 32'h2020;
    step();
    wv = 2'b11; wa[0] = 10'd21; wd[0] = 32'h2121;
    for (int i = 0; i < 2; i++) begin
      #1 chk("lock_addr", ram_w_addr, 10'd20);
      chk("lock_ready", wready, 2'b00);
      step();
    end
    ram_w_rdy = 1'b1;
    #1 chk("lock_release", wready, 2'b10);
    step();
    wv = 2'b01;
    #1 chk("lock_next_req0", wready, 2'b01);
    step();
    wv = '0;
    step();

    // Single write then read back of addr 3.
    wv = 2'b01; wa[0] = 10'd3; wd[0] = 32'h55;
    #1 chk("wr1_ready", wready, 2'b01);
    step();
    wv = '0; rv = 2'b01; ra[0] = 10'd3;
    #1 chk("rd1_ready", rready, 2'b01);
    step();
    rv = '0;
    chk("rd1_rvalid", rresp_valid, 2'b01);
    chk("rd1_rdata", rresp_data, 32'h55);
    step();
    chk("rd1_hold_valid", rresp_valid, 2'b00);
    chk("rd1_hold_data", rresp_data, 32'h55);

    // Concurrent write (req0) and read (req1) of the same address.
    wv = 2'b01; wa[0] = 10'd7; wd[0] = 32'hAB;
    rv = 2'b10; ra[1] = 10'd7;
    #1 chk("conc_wready", wready, 2'b01);
    chk("conc_rready", rready, 2'b10);
    step();
    wv = '0; rv = '0;
    chk("conc_rvalid", rresp_valid, 2'b10);
    chk("conc_rdata", rresp_data, 32'hAB);
    step();

    // Clock enable low: no accept, state frozen.
    cke = 1'b0;
    wv = 2'b01; wa[0] = 10'd9; wd[0] = 32'h99;
    #1 chk("cke_ready", wready, 2'b00);
    step();
    step();
    cke = 1'b1;
    step();
    wv = '0;
    step();

    // Randomized traffic with random RAM backpressure.
    allow_new = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (c == 390) allow_new = 1'b0;
      ram_w_rdy = ($urandom_range(0, 3) != 0) || !allow_new;
      ram_r_rdy = ($urandom_range(0, 3) != 0) || !allow_new;
      for (int k = 0; k < N; k++) begin
        if (last_wacc == k) pend_w[k] = 0;
        if (last_racc == k) pend_r[k] = 0;
        if (!pend_w[k] && allow_new && $urandom_range(0, 1) == 1) begin
          pend_w[k] = 1; wa[k] = AW'($urandom_range(0, 15)); wd[k] = $urandom;
        end
        if (!pend_r[k] && allow_new && $urandom_range(0, 1) == 1) begin
          pend_r[k] = 1; ra[k] = AW'($urandom_range(0, 15));
        end
        wv[k] = pend_w[k];
        rv[k] = pend_r[k];
      end
      step();
    end
    wv = '0; rv = '0; ram_w_rdy = 1'b1; ram_r_rdy = 1'b1;
    step();
    step();

    // Reset asserted right after a read accept, before the response edge.
    rv = 2'b01; ra[0] = 10'd3;
    #1 chk("rst_mid_rready", rready, 2'b01);
    #1 arst_n = 1'b0;
    model_reset();
    #1 chk("rst_mid_ren", ram_r_en, 1'b0);
    step();
    chk("rst_mid_no_pulse", rresp_valid, 2'b00);
    rv = '0;
    step();
    arst_n = 1'b1;
    step();
    chk("rst_rdata_zero", rresp_data, 32'h0);
    wv = 2'b11;
    #1 chk("rst_ptr_zero", wready, 2'b01);
    step();
    wv = 2'b10;
    step();
    wv = '0;
    step();

`ifdef IOB_RAM_2P_ARB_STATS_EN
    // Stall counters: count, clear, saturate.
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    ram_w_rdy = 1'b0;
    wv = 2'b10; wa[1] = 10'd5; wd[1] = 32'h5;
    repeat (5) step();
    chk("stall_five", stall_cnt[31:16], 16'd5);
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("stall_clear", stall_cnt[31:16], 16'd0);
    repeat (70000) @(posedge clk);
    #1;
    stall_m[1] = 16'hFFFF;
    chk("stall_saturate", stall_cnt[31:16], 16'hFFFF);
    step();
    ram_w_rdy = 1'b1;
    step();
    wv = '0;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
